// File: rtl/dilithium_pkg.sv
// Shared Dilithium packing constants, FSM state type and size helpers
// used by the pk/sk/sig streaming packers.
package dilithium_pkg;

  localparam int SEEDBYTES          = 32;
  localparam int N                  = 256;
  localparam int T1_BITS            = 10;
  localparam int POLYT1_PACKEDBYTES = 320;

  typedef enum logic [1:0] {
    IDLE,
    RHO,
    T1,
    DRAIN
  } pk_state_t;

  // 64-bit words in a public key: rho followed by K packed t1 polynomials
  function automatic int pk_words(input int k);
    return (SEEDBYTES / 8) + (POLYT1_PACKEDBYTES / 8) * k;
  endfunction

endpackage

// File: rtl/bit_acc_64.sv
// LSB-first bit accumulator: narrow fields are OR-ed in above the current fill
// level and complete 64-bit words are shifted out from the bottom.
module bit_acc_64 #(
  parameter int IN_W = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            push,
  input  logic [IN_W-1:0] push_data,
  input  logic            pop,
  output logic [63:0]     word,
  output logic            can_push,
  output logic            can_pop,
  output logic            empty
);

  localparam int ACC_W = 64 + IN_W;

  logic [ACC_W-1:0] acc;
  logic [6:0]       cnt;

  // push is only legal below 64 bits and pop only at or above, so they never collide
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (clear) begin
      acc <= '0;
      cnt <= '0;
    end else if (push) begin
      acc <= acc | (ACC_W'(push_data) << cnt);
      cnt <= cnt + 7'(IN_W);
    end else if (pop) begin
      acc <= acc >> 64;
      cnt <= cnt - 7'd64;
    end
  end

  assign word     = acc[63:0];
  assign can_push = (cnt < 7'd64);
  assign can_pop  = (cnt >= 7'd64);
  assign empty    = (cnt == 7'd0);

endmodule

// File: rtl/pk_pack_stream.sv
// Streaming Dilithium public-key packer: emits rho || polyt1_pack(t1[0..K-1])
// as 64-bit words with valid/ready flow control on both sides.
module pk_pack_stream
  import dilithium_pkg::*;
#(
  parameter int K     = 6,
  parameter int OUT_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [255:0]     rho_in,
  input  logic             t1_valid,
  output logic             t1_ready,
  input  logic [31:0]      t1_data,
  output logic             pk_valid,
  input  logic             pk_ready,
  output logic [OUT_W-1:0] pk_data,
  output logic             pk_last,
  output logic             busy,
  output logic             done,
  output logic             err_range
);

  if (!(K == 4 || K == 6 || K == 8)) begin : g_bad_k
    $error("pk_pack_stream: K must be 4, 6 or 8");
  end
  if (OUT_W != 64) begin : g_bad_w
    $error("pk_pack_stream: OUT_W must be 64");
  end

  localparam logic [11:0] TOTAL_COEFS = 12'(N * K);
  localparam logic [8:0]  LAST_WORD   = 9'(pk_words(K) - 1);

  pk_state_t    state, state_next;
  logic [255:0] rho_q;
  logic [1:0]   rho_idx;
  logic [8:0]   word_cnt;
  logic [11:0]  coef_cnt;

  logic         slot_free, xfer, last_xfer, start_go;
  logic         load_rho, emit_t1, accept;
  logic [63:0]  acc_word;
  logic         acc_can_push, acc_can_pop, acc_empty;

  assign slot_free = !pk_valid || pk_ready;
  assign xfer      = pk_valid && pk_ready;
  assign last_xfer = xfer && pk_last;
  // a start coinciding with done is dropped and must be reissued
  assign start_go  = start && (state == IDLE) && !done;
  assign load_rho  = (state == RHO) && slot_free;
  assign emit_t1   = (state == T1) && acc_can_pop && slot_free;
  assign t1_ready  = (state == T1) && acc_can_push && (coef_cnt < TOTAL_COEFS);
  assign accept    = t1_valid && t1_ready;
  assign busy      = (state != IDLE);

  bit_acc_64 #(.IN_W(T1_BITS)) u_acc (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (start_go),
    .push     (accept),
    .push_data(t1_data[T1_BITS-1:0]),
    .pop      (emit_t1),
    .word     (acc_word),
    .can_push (acc_can_push),
    .can_pop  (acc_can_pop),
    .empty    (acc_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_go) state_next = RHO;
      RHO:     if (load_rho && rho_idx == 2'd3) state_next = T1;
      T1:      if (coef_cnt == TOTAL_COEFS && acc_empty) state_next = DRAIN;
      DRAIN:   if (last_xfer) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // the final word can be taken before T1 notices the accumulator is empty
    if (last_xfer) state_next = IDLE;
  end

  // word 0 is loaded straight from rho_in on start so it is valid next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pk_valid  <= 1'b0;
      pk_data   <= '0;
      pk_last   <= 1'b0;
      rho_q     <= '0;
      rho_idx   <= '0;
      word_cnt  <= '0;
      coef_cnt  <= '0;
      err_range <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= last_xfer;
      if (start_go) begin
        rho_q     <= rho_in;
        rho_idx   <= 2'd1;
        word_cnt  <= 9'd1;
        coef_cnt  <= '0;
        err_range <= 1'b0;
        pk_data   <= rho_in[63:0];
        pk_valid  <= 1'b1;
        pk_last   <= 1'b0;
      end else begin
        if (accept) begin
          coef_cnt <= coef_cnt + 12'd1;
          if (|t1_data[31:T1_BITS]) err_range <= 1'b1;
        end
        if (load_rho) begin
          pk_data  <= rho_q[{rho_idx, 6'd0} +: 64];
          pk_valid <= 1'b1;
          pk_last  <= 1'b0;
          rho_idx  <= rho_idx + 2'd1;
          word_cnt <= word_cnt + 9'd1;
        end else if (emit_t1) begin
          pk_data  <= acc_word;
          pk_valid <= 1'b1;
          pk_last  <= (word_cnt == LAST_WORD);
          word_cnt <= word_cnt + 9'd1;
        end else if (xfer) begin
          pk_valid <= 1'b0;
          pk_last  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pk_pack_stream.sv
// Scoreboard bench for pk_pack_stream (K=6): a byte-level polyt1_pack model
// fills the expected queue, a negedge monitor pops and compares each word.
module tb_pk_pack_stream;

  localparam int K      = 6;
  localparam int NWORDS = 4 + 40 * K;
  localparam int NCOEF  = 256 * K;
  localparam int NBYTES = 32 + 320 * K;

  logic         clk, rst_n, start;
  logic [255:0] rho_in;
  logic         t1_valid, t1_ready;
  logic [31:0]  t1_data;
  logic         pk_valid, pk_ready, pk_last;
  logic [63:0]  pk_data;
  logic         busy, done, err_range;

  pk_pack_stream #(.K(K), .OUT_W(64)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .rho_in   (rho_in),
    .t1_valid (t1_valid),
    .t1_ready (t1_ready),
    .t1_data  (t1_data),
    .pk_valid (pk_valid),
    .pk_ready (pk_ready),
    .pk_data  (pk_data),
    .pk_last  (pk_last),
    .busy     (busy),
    .done     (done),
    .err_range(err_range)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_vec = 0;
  int          n_miss = 0;
  logic [31:0] raw[0:NCOEF-1];
  logic [7:0]  rho_b[0:31];
  logic [63:0] cap[0:NWORDS-1];
  int          hs_count;
  int          last_idx;
  bit          stall_prev = 0;
  bit          last_prev = 0;
  logic [63:0] held_data;
  logic        held_last;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  // reference polyt1_pack: 4 coefficients -> 5 bytes
  task automatic buildExpected();
    logic [7:0] b[0:NBYTES-1];
    int a0, a1, a2, a3, base;
    exp_t e;
    for (int i = 0; i < 32; i++) b[i] = rho_b[i];
    for (int p = 0; p < K; p++) begin
      for (int g = 0; g < 64; g++) begin
        a0 = int'(raw[p*256 + 4*g + 0][9:0]);
        a1 = int'(raw[p*256 + 4*g + 1][9:0]);
        a2 = int'(raw[p*256 + 4*g + 2][9:0]);
        a3 = int'(raw[p*256 + 4*g + 3][9:0]);
        base = 32 + 320*p + 5*g;
        b[base + 0] = 8'(a0);
        b[base + 1] = 8'((a0 >> 8) | (a1 << 2));
        b[base + 2] = 8'((a1 >> 6) | (a2 << 4));
        b[base + 3] = 8'((a2 >> 4) | (a3 << 6));
        b[base + 4] = 8'(a3 >> 2);
      end
    end
    for (int w = 0; w < NWORDS; w++) begin
      for (int k = 0; k < 8; k++) e.data[8*k +: 8] = b[8*w + k];
      e.last = (w == NWORDS - 1);
      exp_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 0;
      last_prev  = 0;
    end else begin
      if (last_prev) begin
        checkOutput("done_pulse", done, 1);
        checkOutput("busy_after_done", busy, 0);
        last_prev = 0;
      end
      if (stall_prev) begin
        checkOutput("stall_valid", pk_valid, 1);
        checkOutput("stall_data", pk_data, held_data);
        checkOutput("stall_last", pk_last, held_last);
      end
      if (pk_valid && pk_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("[TB] FAIL unexpected_word: got 0x%h, expected no word", pk_data);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput($sformatf("word%0d_data", hs_count), pk_data, mon_e.data);
          checkOutput($sformatf("word%0d_last", hs_count), pk_last, mon_e.last);
        end
        if (hs_count < NWORDS) cap[hs_count] = pk_data;
        if (pk_last) begin
          last_idx  = hs_count;
          last_prev = 1;
        end
        hs_count++;
      end
      stall_prev = pk_valid && !pk_ready;
      held_data  = pk_data;
      held_last  = pk_last;
    end
  end

  task automatic applyStimulus(input bit bp, input bit rand_valid, input int rst_at, input bit poke_start);
    bit           done_seen = 0;
    bit           exp_err = 0;
    int           idx = 0;
    int           cyc = 0;
    logic [255:0] rho_packed;
    logic [63:0]  w0;
    for (int i = 0; i < 32; i++) rho_packed[8*i +: 8] = rho_b[i];
    for (int i = 0; i < 8; i++) w0[8*i +: 8] = rho_b[i];
    for (int i = 0; i < NCOEF; i++) if (raw[i][31:10] != 0) exp_err = 1;
    hs_count = 0;
    last_idx = -1;
    buildExpected();
    @(posedge clk); #1;
    start = 1; rho_in = rho_packed; t1_valid = 0; pk_ready = 0;
    @(negedge clk);
    checkOutput("busy_before_start", busy, 0);
    @(posedge clk); #1;
    start = 0;
    rho_in = ~rho_packed;
    while (!done_seen && cyc < 12000) begin
      if (rst_at > 0 && hs_count >= rst_at) begin
        rst_n = 0;
        #1;
        checkOutput("rst_t1_ready", t1_ready, 0);
        checkOutput("rst_pk_valid", pk_valid, 0);
        checkOutput("rst_pk_data", pk_data, 0);
        checkOutput("rst_pk_last", pk_last, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_err_range", err_range, 0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1; t1_valid = 0; pk_ready = 0;
        return;
      end
      start = poke_start && (cyc == 500);
      if (idx < NCOEF) begin
        t1_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
        t1_data  = raw[idx];
      end else begin
        t1_valid = 0;
        t1_data  = 0;
      end
      pk_ready = bp ? ($urandom_range(0, 9) < 3) : 1'b1;
      @(negedge clk);
      if (cyc == 0) begin
        checkOutput("first_valid", pk_valid, 1);
        checkOutput("first_busy", busy, 1);
        checkOutput("first_word", pk_data, w0);
        checkOutput("err_cleared_by_start", err_range, 0);
      end
      if (t1_valid && t1_ready) idx++;
      if (done) done_seen = 1;
      cyc++;
      @(posedge clk); #1;
    end
    start = 0; t1_valid = 0; pk_ready = 0;
    checkOutput("done_seen", done_seen, 1);
    checkOutput("words_left", exp_q.size(), 0);
    checkOutput("last_index", last_idx, NWORDS - 1);
    checkOutput("err_range_end", err_range, exp_err);
    exp_q.delete();
  endtask

  task automatic setRamp(input logic [7:0] rho_x);
    for (int i = 0; i < 32; i++) rho_b[i] = rho_x ^ 8'(i);
    for (int p = 0; p < K; p++)
      for (int j = 0; j < 256; j++) raw[p*256 + j] = 32'((j + 97*p) & 10'h3FF);
  endtask

  initial begin
    rst_n = 0; start = 0; rho_in = '0; t1_valid = 0; t1_data = '0; pk_ready = 0;
    #12;
    checkOutput("reset_t1_ready", t1_ready, 0);
    checkOutput("reset_pk_valid", pk_valid, 0);
    checkOutput("reset_pk_data", pk_data, 0);
    checkOutput("reset_pk_last", pk_last, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_err_range", err_range, 0);
    @(posedge clk); #1;
    rst_n = 1;

    for (int i = 0; i < 32; i++) rho_b[i] = 8'(i);
    for (int i = 0; i < NCOEF; i++) raw[i] = 32'd0;
    $display("[TB] zero t1, counting rho");
    applyStimulus(0, 0, 0, 0);
    checkOutput("zero_word0", cap[0], 64'h0706050403020100);
    checkOutput("zero_word3", cap[3], 64'h1F1E1D1C1B1A1918);
    checkOutput("zero_word4", cap[4], 64'h0);
    checkOutput("zero_word243", cap[243], 64'h0);

    setRamp(8'hA0);
    $display("[TB] ramp t1");
    applyStimulus(0, 0, 0, 0);
    checkOutput("ramp_word4", cap[4], 64'h60140400C0200400);

    for (int i = 0; i < NCOEF; i++) raw[i] = 32'd1023;
    $display("[TB] all-ones t1");
    applyStimulus(0, 0, 0, 0);
    checkOutput("ones_word4", cap[4], 64'hFFFFFFFFFFFFFFFF);
    checkOutput("ones_word243", cap[243], 64'hFFFFFFFFFFFFFFFF);

    setRamp(8'h5C);
    $display("[TB] backpressure, random t1_valid, start while busy");
    applyStimulus(1, 1, 0, 1);
    checkOutput("bp_word4", cap[4], 64'h60140400C0200400);

    setRamp(8'h33);
    raw[5] = 32'h0000_0400;
    $display("[TB] out-of-range coefficient");
    applyStimulus(0, 0, 0, 0);
    checkOutput("err_word4", cap[4], 64'h60000400C0200400);

    setRamp(8'h77);
    $display("[TB] reset at word 100");
    applyStimulus(0, 0, 100, 0);
    $display("[TB] full pk after reset");
    applyStimulus(0, 0, 0, 0);
    checkOutput("post_rst_word4", cap[4], 64'h60140400C0200400);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
